// File: rtl/text_pkg.sv
// Shared constants, state/cursor-op encodings and address helper for the text writer.
// TEXT_WRITER_LINE_CLEAR_EN adds the CLEAR state to the state enum.
package text_pkg;

   localparam int COLS_DEF = 80;
   localparam int ROWS_DEF = 30;
   localparam int ADDR_W   = 12;
   localparam int COL_W    = 7;
   localparam int ROW_W    = 5;

   localparam logic [7:0] CHAR_LF       = 8'h0A;
   localparam logic [7:0] CHAR_CR       = 8'h0D;
   localparam logic [7:0] CHAR_BS       = 8'h08;
   localparam logic [7:0] CHAR_SPACE    = 8'h20;
   localparam logic [7:0] CHAR_PRINT_LO = CHAR_SPACE;
   localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

`ifdef TEXT_WRITER_LINE_CLEAR_EN
   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

   typedef enum logic [2:0] {OP_NONE, OP_INC, OP_LF, OP_CR, OP_BS} cur_op_t;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } cursor_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CHAR_PRINT_LO) && (c <= CHAR_PRINT_HI);
   endfunction

   // COLS*ROWS must fit the 12-bit address space.
   function automatic logic [ADDR_W-1:0] calc_addr(input cursor_t p, input int cols);
      return ADDR_W'(p.row) * ADDR_W'(cols) + ADDR_W'(p.col);
   endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor counters: column advance with end-of-row wrap, row wrap without scrolling, clamped backspace.
// Updates on the clk edge where op is presented; op is a one-cycle command with no handshake.
module text_cursor
   import text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic    clk,
   input  logic    rst,
   input  cur_op_t op,
   output cursor_t pos
);

   logic [ROW_W-1:0] row_inc;
   logic             eol;

   assign eol     = (pos.col == COL_W'(COLS - 1));
   assign row_inc = (pos.row == ROW_W'(ROWS - 1)) ? '0 : pos.row + ROW_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos <= '0;
      end else begin
         case (op)
            OP_INC: begin
               if (eol) begin
                  pos.col <= '0;
                  pos.row <= row_inc;
               end else begin
                  pos.col <= pos.col + COL_W'(1);
               end
            end
            OP_LF: begin
               pos.col <= '0;
               pos.row <= row_inc;
            end
            OP_CR: pos.col <= '0;
            OP_BS: begin
               if (pos.col != '0) pos.col <= pos.col - COL_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/text_writer.sv
// Text writer: byte stream into a COLS x ROWS char memory; a printable byte writes 1 cycle after accept (1 byte per 2 cycles).
// Backpressure: char_ready only in IDLE; TEXT_WRITER_LINE_CLEAR_EN blanks each newly entered row (COLS cycles).
module text_writer
   import text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        char_in,
   input  logic              char_valid,
   output logic              char_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic [COL_W-1:0]  cursor_col,
   output logic [ROW_W-1:0]  cursor_row
);

   state_t  state;
   cur_op_t op;
   cursor_t pos;
   logic    accept;

   assign accept     = char_valid & char_ready;
   assign cursor_col = pos.col;
   assign cursor_row = pos.row;

   always_comb begin
      op = OP_NONE;
      if (state == WRITE) begin
         op = OP_INC;
      end else if (accept) begin
         case (char_in)
            CHAR_LF: op = OP_LF;
            CHAR_CR: op = OP_CR;
            CHAR_BS: op = OP_BS;
            default: op = OP_NONE;
         endcase
      end
   end

   text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
      .clk (clk),
      .rst (rst),
      .op  (op),
      .pos (pos)
   );

`ifdef TEXT_WRITER_LINE_CLEAR_EN
   logic [COL_W-1:0] clr_cnt;
   cursor_t          nl_pos;

   // First cell of the row that a row advance from the current cursor lands on.
   assign nl_pos = '{row: (pos.row == ROW_W'(ROWS - 1)) ? '0 : pos.row + ROW_W'(1), col: '0};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         char_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
         clr_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               char_ready <= 1'b1;
               if (accept && is_printable(char_in)) begin
                  state      <= WRITE;
                  char_ready <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_addr   <= calc_addr(pos, COLS);
                  mem_din    <= char_in;
               end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
               else if (accept && (char_in == CHAR_LF)) begin
                  state      <= CLEAR;
                  char_ready <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_addr   <= calc_addr(nl_pos, COLS);
                  mem_din    <= CHAR_SPACE;
                  clr_cnt    <= '0;
               end
`endif
            end
            WRITE: begin
`ifdef TEXT_WRITER_LINE_CLEAR_EN
               if (pos.col == COL_W'(COLS - 1)) begin
                  state    <= CLEAR;
                  mem_we   <= 1'b1;
                  mem_addr <= calc_addr(nl_pos, COLS);
                  mem_din  <= CHAR_SPACE;
                  clr_cnt  <= '0;
               end else
`endif
               begin
                  state      <= IDLE;
                  char_ready <= 1'b1;
                  mem_we     <= 1'b0;
               end
            end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
            CLEAR: begin
               if (clr_cnt == COL_W'(COLS - 1)) begin
                  state      <= IDLE;
                  char_ready <= 1'b1;
                  mem_we     <= 1'b0;
               end else begin
                  clr_cnt  <= clr_cnt + COL_W'(1);
                  mem_addr <= mem_addr + ADDR_W'(1);
               end
            end
`endif
            default: begin
               state      <= IDLE;
               char_ready <= 1'b0;
               mem_we     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: reset, printing, row wrap, LF/CR/BS, mid-operation reset, continuous valid.
// Expectations come from hand-derived constants and a small cursor/write model.
module tb_text_writer;

   logic        clk, rst;
   logic [7:0]  char_in;
   logic        char_valid, char_ready, mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_din;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int wa[$];
   int wd[$];
   int acc_cyc[$];
   int ea[$];
   int ed[$];

   text_writer dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         wa.push_back(int'(mem_addr));
         wd.push_back(int'(mem_din));
      end
      if (char_valid && char_ready) begin
         acc_cnt++;
         acc_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      acc_cyc.delete();
   endtask

   task automatic do_reset();
      char_valid = 1'b0;
      char_in    = 8'h00;
      rst        = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_log();
   endtask

   // Offer one byte (starting just after a rising edge) and hold it until taken.
   task automatic send(input logic [7:0] b);
      logic acc;
      int   t;
      acc = 1'b0;
      t   = 0;
      char_in    = b;
      char_valid = 1'b1;
      while (!acc && t < 1000) begin
         @(negedge clk);
         acc = char_ready;
         @(posedge clk);
         #1;
         t++;
      end
      char_valid = 1'b0;
      if (!acc) check("send_timeout", 32'(acc), 1);
   endtask

   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      @(negedge clk);
      while (char_ready !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (char_ready !== 1'b1) check({tag, "_ready_timeout"}, 32'(char_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear(input int r);
`ifdef TEXT_WRITER_LINE_CLEAR_EN
      for (int i = 0; i < 80; i++) begin
         ea.push_back(r * 80 + i);
         ed.push_back(32);
      end
`else
      if (r < 0) ea.push_back(0);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad, last_a, last_d, n29, a0, idx, viol, t, mc, mr, r;
      logic acc;
      logic [7:0] stim [200];

      rst = 1'b1;
      char_valid = 1'b0;
      char_in = 8'h00;
      #3;
      check("rst_ready", 32'(char_ready), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_din", 32'(mem_din), 0);
      check("rst_col", 32'(cursor_col), 0);
      check("rst_row", 32'(cursor_row), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_before_edge", 32'(char_ready), 0);
      @(posedge clk);
      #1;
      check("ready_after_release", 32'(char_ready), 1);
      clear_log();

      // Single 'A' at (0,0)
      send(8'h41);
      check("a_we", 32'(mem_we), 1);
      check("a_addr", 32'(mem_addr), 0);
      check("a_din", 32'(mem_din), 32'h41);
      wait_ready("a");
      check("a_col", 32'(cursor_col), 1);
      check("a_row", 32'(cursor_row), 0);
      check("a_nwrites", wa.size(), 1);

      // Full row of printable bytes
      do_reset();
      for (int i = 0; i < 80; i++) send(8'(33 + i));
      wait_ready("row0");
      last_a = (wa.size() >= 80) ? wa[79] : -1;
      last_d = (wd.size() >= 80) ? wd[79] : -1;
      check("row0_last_addr", last_a, 79);
      check("row0_last_din", last_d, 32'h70);
      bad = 0;
      for (int i = 0; i < 80; i++)
         if (i >= wa.size() || wa[i] != i || wd[i] != 33 + i) bad++;
      check("row0_writes", bad, 0);
      check("row0_gap_first", (acc_cyc.size() >= 80) ? acc_cyc[1] - acc_cyc[0] : -1, 2);
      check("row0_gap_last", (acc_cyc.size() >= 80) ? acc_cyc[79] - acc_cyc[78] : -1, 2);
      check("row0_col", 32'(cursor_col), 0);
      check("row0_row", 32'(cursor_row), 1);
`ifdef TEXT_WRITER_LINE_CLEAR_EN
      check("row0_nwrites", wa.size(), 160);
      bad = 0;
      for (int i = 80; i < 160; i++)
         if (i >= wa.size() || wa[i] != i || wd[i] != 32) bad++;
      check("row1_clear", bad, 0);
`else
      check("row0_nwrites", wa.size(), 80);
`endif

      // LF from the last row wraps to row 0
      do_reset();
      repeat (29) send(8'h0A);
      repeat (5) send(8'h78);
      wait_ready("goto");
      check("goto_col", 32'(cursor_col), 5);
      check("goto_row", 32'(cursor_row), 29);
      clear_log();
      send(8'h0A);
      wait_ready("lf29");
      check("lf29_col", 32'(cursor_col), 0);
      check("lf29_row", 32'(cursor_row), 0);
      n29 = 0;
      foreach (wa[i]) if (wa[i] >= 2320 && wa[i] < 2400) n29++;
      check("lf29_row29_writes", n29, 0);
`ifdef TEXT_WRITER_LINE_CLEAR_EN
      check("lf29_nwrites", wa.size(), 80);
      bad = 0;
      for (int i = 0; i < 80; i++)
         if (i >= wa.size() || wa[i] != i || wd[i] != 32) bad++;
      check("lf29_clear", bad, 0);
`else
      check("lf29_nwrites", wa.size(), 0);
`endif

      // BS at column 0, ignored byte, BS/CR mid-row
      do_reset();
      repeat (3) send(8'h0A);
      wait_ready("goto3");
      clear_log();
      a0 = acc_cnt;
      send(8'h08);
      wait_ready("bs0");
      check("bs0_col", 32'(cursor_col), 0);
      check("bs0_row", 32'(cursor_row), 3);
      check("bs0_nwrites", wa.size(), 0);
      send(8'h7F);
      wait_ready("del");
      check("del_col", 32'(cursor_col), 0);
      check("del_row", 32'(cursor_row), 3);
      check("del_nwrites", wa.size(), 0);
      check("del_accepted", acc_cnt - a0, 2);
      send(8'h61);
      send(8'h62);
      send(8'h08);
      wait_ready("bs2");
      check("bs2_col", 32'(cursor_col), 1);
      send(8'h0D);
      wait_ready("cr");
      check("cr_col", 32'(cursor_col), 0);
      check("cr_row", 32'(cursor_row), 3);

      // Reset while a write is in flight
      do_reset();
      send(8'h41);
      check("midwr_we_before", 32'(mem_we), 1);
      rst = 1'b1;
      #1;
      check("midwr_we", 32'(mem_we), 0);
      check("midwr_din", 32'(mem_din), 0);
      check("midwr_ready", 32'(char_ready), 0);
      check("midwr_col", 32'(cursor_col), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midwr_ready_after", 32'(char_ready), 1);

`ifdef TEXT_WRITER_LINE_CLEAR_EN
      // Reset on the 40th clear cycle
      do_reset();
      send(8'h0A);
      repeat (39) @(posedge clk);
      #1;
      check("clr40_we", 32'(mem_we), 1);
      check("clr40_addr", 32'(mem_addr), 119);
      rst = 1'b1;
      #1;
      check("clrrst_we", 32'(mem_we), 0);
      check("clrrst_col", 32'(cursor_col), 0);
      check("clrrst_row", 32'(cursor_row), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("clrrst_ready", 32'(char_ready), 1);
      repeat (100) @(posedge clk);
      #1;
      check("clrrst_nwrites", wa.size(), 39);
`endif

      // Continuous valid with a random byte stream
      do_reset();
      ea.delete();
      ed.delete();
      mc = 0;
      mr = 0;
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 31);
         case (r)
            0: stim[i] = 8'h0A;
            1: stim[i] = 8'h0D;
            2: stim[i] = 8'h08;
            3: stim[i] = 8'h7F;
            4: stim[i] = 8'(128 + $urandom_range(0, 127));
            default: stim[i] = 8'($urandom_range(32, 126));
         endcase
         if (stim[i] >= 8'h20 && stim[i] <= 8'h7E) begin
            ea.push_back(mr * 80 + mc);
            ed.push_back(int'(stim[i]));
            mc++;
            if (mc == 80) begin
               mc = 0;
               mr = (mr + 1) % 30;
               model_clear(mr);
            end
         end else if (stim[i] == 8'h0A) begin
            mc = 0;
            mr = (mr + 1) % 30;
            model_clear(mr);
         end else if (stim[i] == 8'h0D) begin
            mc = 0;
         end else if (stim[i] == 8'h08) begin
            if (mc > 0) mc--;
         end
      end
      a0 = acc_cnt;
      idx = 0;
      viol = 0;
      t = 0;
      char_in = stim[0];
      char_valid = 1'b1;
      while (idx < 200 && t < 20000) begin
         @(negedge clk);
         if (char_ready && mem_we) viol++;
         acc = char_ready;
         @(posedge clk);
         #1;
         t++;
         if (acc) begin
            idx++;
            if (idx < 200) char_in = stim[idx];
         end
      end
      char_valid = 1'b0;
      wait_ready("rand");
      check("rand_consumed", idx, 200);
      check("rand_accepted", acc_cnt - a0, 200);
      check("rand_ready_while_busy", viol, 0);
      check("rand_nwrites", wa.size(), ea.size());
      bad = 0;
      foreach (ea[i])
         if (i >= wa.size() || wa[i] != ea[i] || wd[i] != ed[i]) bad++;
      check("rand_writes", bad, 0);
      check("rand_col", 32'(cursor_col), mc);
      check("rand_row", 32'(cursor_row), mr);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter COLS, default 80: text columns per row.
REQ-002 SHALL have parameter ROWS, default 30: text rows.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port char_in, input, 8: byte offered by the producer.
REQ-006 SHALL have port char_valid, input, 1: char_in is valid.
REQ-007 SHALL have port char_ready, output, 1: the block accepts char_in this cycle.
REQ-008 SHALL have port mem_we, output, 1: write strobe into text memory port A.
REQ-009 SHALL have port mem_addr, output, 12: text memory address, row*COLS+col.
REQ-010 SHALL have port mem_din, output, 8: character code written.
REQ-011 SHALL have port cursor_col, output, 7: current column, 0..COLS-1.
REQ-012 SHALL have port cursor_row, output, 5: current row, 0..ROWS-1.

Function
REQ-013 SHALL accept a byte only on a rising clk edge with char_valid=1 and char_ready=1.
REQ-014 SHALL implement states IDLE, WRITE and CLEAR; char_ready SHALL be 1 only in IDLE.
REQ-015 SHALL handle a printable byte accepted in IDLE (0x20..0x7E) as follows: go to WRITE; in the next cycle mem_we=1, mem_din=byte, mem_addr=row*COLS+col, all registered.
REQ-016 SHALL, in WRITE, advance col by 1; at col=COLS-1, set col to 0 and advance row.
REQ-017 SHALL handle LF (0x0A) in IDLE as: col to 0, advance row, no memory write.
REQ-018 SHALL handle CR (0x0D) in IDLE as: col to 0, no memory write.
REQ-019 SHALL handle BS (0x08) in IDLE as: col decremented if col>0, otherwise unchanged; row unchanged; no write.
REQ-020 SHALL accept and discard all other bytes with no state change.
REQ-021 SHALL wrap a row advance from ROWS-1 to row 0; there is no scrolling.
REQ-022 SHALL, after any row advance, go to CLEAR if the clear feature is compiled in (REQ-028); otherwise it SHALL go to IDLE.
REQ-023 SHALL, in CLEAR, write 0x20 to addresses newrow*COLS+0 .. newrow*COLS+COLS-1, one per cycle with mem_we=1 for exactly COLS cycles, then go to IDLE.
REQ-024 SHALL hold mem_we at 0 in IDLE; mem_addr and mem_din SHALL hold their last values when mem_we=0.
REQ-025 SHALL give a printable byte a throughput of 1 byte per 2 cycles when no row advance occurs.
REQ-026 SHALL compute mem_addr at 12 bits; COLS*ROWS SHALL NOT exceed 4096.

Reset
REQ-027 SHALL, on rst=1 at any time (including mid-WRITE or mid-CLEAR), immediately set state=IDLE, char_ready=0, mem_we=0, mem_addr=0, mem_din=0, cursor_col=0, cursor_row=0; char_ready SHALL rise on the first clk edge after rst falls. The abandoned clear is not resumed.

Configuration
REQ-028 SHALL enable the CLEAR state and line clearing on row advance when the macro TEXT_WRITER_LINE_CLEAR_EN is defined.
REQ-029 SHALL, when TEXT_WRITER_LINE_CLEAR_EN is undefined, have no CLEAR state; a row advance SHALL return to IDLE and old row contents SHALL persist.

Structure
REQ-030 SHALL take its constants from the shared package text_pkg: default COLS and ROWS, address width 12, codes CHAR_LF, CHAR_CR, CHAR_BS, CHAR_SPACE, printable bounds, and the state enum.
REQ-031 SHALL place the col/row counters with wrap, backspace and advance logic in the sub-module text_cursor; the state machine and memory port SHALL stay in text_writer.

Verification
REQ-032 SHALL cover: reset, then send 'A' (0x41) -> one cycle later mem_we=1, mem_addr=0, mem_din=0x41; cursor_col=1.
REQ-033 SHALL cover: 80 printable bytes from (0,0) -> last write at addr 79; cursor=(0,1); with the clear feature, 80 writes of 0x20 at addrs 80..159.
REQ-034 SHALL cover: cursor (5,29), send LF -> cursor=(0,0); with the clear feature, clear of addrs 0..79; no write to row 29.
REQ-035 SHALL cover: cursor (0,3), send BS -> cursor unchanged, no mem_we; send 0x7F -> accepted and ignored.
REQ-036 SHALL cover: assert rst on the 40th CLEAR cycle -> mem_we=0 and cursor=(0,0) immediately; char_ready=1 one edge after release.
REQ-037 SHALL cover: char_valid held high continuously with random bytes -> no byte lost or duplicated; acceptance only when char_ready=1.
